// File: rtl/serial_pattern_matcher_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_pattern_matcher_pkg : shared defaults and FSM state type
// Revision 1.0
// ---------------------------------------------------------------------------
package serial_pattern_matcher_pkg;

  localparam int DEF_PAT_W = 10;
  localparam int DEF_DIV   = 6;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HUNT = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_pattern_matcher_tick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sample_tick_gen : enable-gated prescaler producing a one-clk sample tick
// Revision 1.0
// ---------------------------------------------------------------------------
module sample_tick_gen
  import serial_pattern_matcher_pkg::*;
#(
  parameter int DIV = DEF_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  // Qualified with reset so DIV=1 cannot tick while reset is held.
  assign tick = en && rst_n && (count == LAST);

endmodule
`default_nettype wire

// File: rtl/serial_pattern_matcher.sv
`default_nettype none
// ---------------------------------------------------------------------------
// serial_pattern_matcher : masked serial pattern detector with match counter
// Revision 1.0
// ---------------------------------------------------------------------------
module serial_pattern_matcher
  import serial_pattern_matcher_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int DIV   = DEF_DIV,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             datain_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic [PAT_W-1:0] mask_i,
  input  logic             mode_i,
  input  logic             clr_i,
  output logic             sample_o,
  output logic             match_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic [PAT_W-1:0] shreg_o
);

  localparam int            FW   = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);

  logic [1:0]       rst_pipe;
  logic             rst_sync_n;
  logic             tick;
  state_t           state, state_nxt;
  logic [PAT_W-1:0] shreg, shreg_nxt;
  logic [FW-1:0]    fill, fill_inc;
  logic             full_nxt;
  logic             hit;
  logic             restart;
  logic             match_q;
  logic [CNT_W-1:0] cnt;

  // Asynchronous assertion, synchronised release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_sync_n = rst_pipe[1];

  sample_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_sync_n),
    .en    (en),
    .tick  (tick)
  );

  assign shreg_nxt = {datain_i, shreg[PAT_W-1:1]};
  assign fill_inc  = (fill == FULL) ? FULL : fill + FW'(1);
  assign full_nxt  = (fill_inc == FULL);
  assign hit       = tick && !clr_i && full_nxt &&
                     (((shreg_nxt ^ pattern_i) & mask_i) == '0);
  assign restart   = hit && mode_i;

  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else if (clr_i) begin
      state_nxt = FILL;
    end else if (tick) begin
      state_nxt = (full_nxt && !restart) ? HUNT : FILL;
    end else if (state == IDLE) begin
      state_nxt = (fill == FULL) ? HUNT : FILL;
    end
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state   <= IDLE;
      shreg   <= '0;
      fill    <= '0;
      match_q <= 1'b0;
      cnt     <= '0;
    end else begin
      state   <= state_nxt;
      match_q <= hit;
      if (clr_i) begin
        shreg <= '0;
        fill  <= '0;
        cnt   <= '0;
      end else begin
        if (tick) begin
          shreg <= shreg_nxt;
          fill  <= restart ? '0 : fill_inc;
        end
        if (hit && (cnt != '1)) cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign sample_o    = tick;
  assign match_o     = match_q;
  assign match_cnt_o = cnt;
  assign shreg_o     = shreg;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_matcher.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_serial_pattern_matcher : directed self-checking bench, three configurations
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_serial_pattern_matcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // A: defaults (PAT_W=10, DIV=6, CNT_W=8)
  logic       en_a, din_a, mode_a, clr_a, samp_a, match_a;
  logic [9:0] pat_a, mask_a, sh_a;
  logic [7:0] cnt_a;
  // B: PAT_W=4, DIV=3
  logic       en_b, din_b, mode_b, clr_b, samp_b, match_b;
  logic [3:0] pat_b, mask_b, sh_b;
  logic [7:0] cnt_b;
  // C: PAT_W=10, DIV=1, CNT_W=2
  logic       en_c, din_c, mode_c, clr_c, samp_c, match_c;
  logic [9:0] pat_c, mask_c, sh_c;
  logic [1:0] cnt_c;

  int vectors = 0;
  int errors  = 0;

  serial_pattern_matcher dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_a), .datain_i(din_a), .pattern_i(pat_a),
    .mask_i(mask_a), .mode_i(mode_a), .clr_i(clr_a), .sample_o(samp_a),
    .match_o(match_a), .match_cnt_o(cnt_a), .shreg_o(sh_a)
  );

  serial_pattern_matcher #(.PAT_W(4), .DIV(3), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b), .datain_i(din_b), .pattern_i(pat_b),
    .mask_i(mask_b), .mode_i(mode_b), .clr_i(clr_b), .sample_o(samp_b),
    .match_o(match_b), .match_cnt_o(cnt_b), .shreg_o(sh_b)
  );

  serial_pattern_matcher #(.PAT_W(10), .DIV(1), .CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_c), .datain_i(din_c), .pattern_i(pat_c),
    .mask_i(mask_c), .mode_i(mode_c), .clr_i(clr_c), .sample_o(samp_c),
    .match_o(match_c), .match_cnt_o(cnt_c), .shreg_o(sh_c)
  );

  // Drive one bit, wait for its tick, return #1 after the tick edge.
  task automatic tick_a(input logic b);
    int n = 0;
    din_a = b;
    @(negedge clk);
    while (!samp_a && n < 100) begin @(negedge clk); n++; end
    if (!samp_a) begin
      vectors++; errors++;
      $display("FAIL tick_a_timeout: sample_o=%b required 1", samp_a);
    end
    @(posedge clk); #1;
  endtask

  task automatic tick_b(input logic b);
    int n = 0;
    din_b = b;
    @(negedge clk);
    while (!samp_b && n < 100) begin @(negedge clk); n++; end
    if (!samp_b) begin
      vectors++; errors++;
      $display("FAIL tick_b_timeout: sample_o=%b required 1", samp_b);
    end
    @(posedge clk); #1;
  endtask

  task automatic tick_c(input logic b);
    int n = 0;
    din_c = b;
    @(negedge clk);
    while (!samp_c && n < 100) begin @(negedge clk); n++; end
    if (!samp_c) begin
      vectors++; errors++;
      $display("FAIL tick_c_timeout: sample_o=%b required 1", samp_c);
    end
    @(posedge clk); #1;
  endtask

  // Clear on a cycle without a tick.
  task automatic clear_a();
    int n = 0;
    @(negedge clk);
    while (samp_a && n < 10) begin @(negedge clk); n++; end
    clr_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
  endtask

  task automatic clear_b();
    int n = 0;
    @(negedge clk);
    while (samp_b && n < 10) begin @(negedge clk); n++; end
    clr_b = 1'b1;
    @(posedge clk); #1;
    clr_b = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    {en_a, din_a, mode_a, clr_a} = '0; pat_a = '0; mask_a = '0;
    {en_b, din_b, mode_b, clr_b} = '0; pat_b = '0; mask_b = '0;
    {en_c, din_c, mode_c, clr_c} = '0; pat_c = '0; mask_c = '0;
    #12;
    vectors++; if (match_a !== 1'b0) begin errors++; $display("FAIL reset_match: got %b want 0", match_a); end
    vectors++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", cnt_a); end
    vectors++; if (sh_a !== 10'd0) begin errors++; $display("FAIL reset_shreg: got %b want 0", sh_a); end
    vectors++; if (samp_a !== 1'b0) begin errors++; $display("FAIL reset_sample: got %b want 0", samp_a); end
    vectors++;
    if ({match_b, cnt_b, sh_b, samp_b, match_c, cnt_c, sh_c, samp_c} !== '0) begin
      errors++;
      $display("FAIL reset_bc: got %h want 0", {match_b, cnt_b, sh_b, samp_b, match_c, cnt_c, sh_c, samp_c});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    en_a = 1'b1; #1;
    n = 1;
    while (!samp_a && n < 50) begin @(negedge clk); #1; n++; end
    vectors++; if (n !== 6) begin errors++; $display("FAIL first_tick_latency: got %0d clk want 6", n); end
  endtask

  task automatic test_basic();
    logic [9:0] s;
    s = 10'b1111011010;
    pat_a = s; mask_a = '1; mode_a = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick_a(s[i]);
      vectors++;
      if (match_a !== (i == 9)) begin errors++; $display("FAIL basic_match[%0d]: got %b want %b", i, match_a, (i == 9)); end
    end
    @(posedge clk); #1;
    vectors++; if (match_a !== 1'b0) begin errors++; $display("FAIL basic_pulse_len: got %b want 0", match_a); end
    vectors++; if (cnt_a !== 8'd1) begin errors++; $display("FAIL basic_cnt: got %0d want 1", cnt_a); end
    vectors++; if (sh_a !== 10'b1111011010) begin errors++; $display("FAIL basic_shreg: got %b want 1111011010", sh_a); end
  endtask

  task automatic test_clear_on_tick();
    logic [9:0] s;
    int n = 0;
    s = 10'b1111011010;
    pat_a = 10'd0;
    for (int i = 0; i < 7; i++) begin
      tick_a(1'b1);
      vectors++;
      if (match_a !== 1'b0) begin errors++; $display("FAIL pre_clear_match[%0d]: got %b want 0", i, match_a); end
    end
    @(negedge clk);
    while (!samp_a && n < 100) begin @(negedge clk); n++; end
    clr_a = 1'b1; din_a = 1'b1;
    @(posedge clk); #1;
    clr_a = 1'b0;
    vectors++; if (sh_a !== 10'd0) begin errors++; $display("FAIL clear_shreg: got %b want 0", sh_a); end
    vectors++; if (cnt_a !== 8'd0) begin errors++; $display("FAIL clear_cnt: got %0d want 0", cnt_a); end
    vectors++; if (match_a !== 1'b0) begin errors++; $display("FAIL clear_match: got %b want 0", match_a); end
    pat_a = s;
    for (int i = 0; i < 10; i++) begin
      tick_a(s[i]);
      vectors++;
      if (match_a !== (i == 9)) begin errors++; $display("FAIL post_clear_match[%0d]: got %b want %b", i, match_a, (i == 9)); end
    end
    vectors++; if (cnt_a !== 8'd1) begin errors++; $display("FAIL post_clear_cnt: got %0d want 1", cnt_a); end
  endtask

  task automatic test_mask();
    logic [15:0] st;
    logic        exp;
    st = 16'b1001_1010_1100_1011;
    clear_a();
    mask_a = 10'b0000000011; pat_a = 10'b1011001110; mode_a = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick_a(st[k-1]);
      exp = (k >= 10) && (st[k-10] == 1'b0) && (st[k-9] == 1'b1);
      vectors++;
      if (match_a !== exp) begin errors++; $display("FAIL mask_match[tick %0d]: got %b want %b", k, match_a, exp); end
    end
    vectors++; if (cnt_a !== 8'd2) begin errors++; $display("FAIL mask_cnt: got %0d want 2", cnt_a); end
  endtask

  task automatic test_overlap();
    logic [5:0] sb, exp0, exp1;
    sb = 6'b010101; exp0 = 6'b101000; exp1 = 6'b001000;
    en_b = 1'b1; pat_b = 4'b0101; mask_b = 4'b1111; mode_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick_b(sb[i]);
      vectors++;
      if (match_b !== exp0[i]) begin errors++; $display("FAIL overlap_match[%0d]: got %b want %b", i, match_b, exp0[i]); end
    end
    vectors++; if (cnt_b !== 8'd2) begin errors++; $display("FAIL overlap_cnt: got %0d want 2", cnt_b); end
    clear_b();
    vectors++; if ({cnt_b, sh_b} !== 12'd0) begin errors++; $display("FAIL clear_b: got %h want 0", {cnt_b, sh_b}); end
    mode_b = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick_b(sb[i]);
      vectors++;
      if (match_b !== exp1[i]) begin errors++; $display("FAIL nonoverlap_match[%0d]: got %b want %b", i, match_b, exp1[i]); end
    end
    vectors++; if (cnt_b !== 8'd1) begin errors++; $display("FAIL nonoverlap_cnt: got %0d want 1", cnt_b); end
    vectors++; if (sh_b !== 4'b0101) begin errors++; $display("FAIL nonoverlap_shreg: got %b want 0101", sh_b); end
  endtask

  task automatic test_saturate();
    logic [1:0] exp_cnt;
    en_c = 1'b1; mask_c = '0; pat_c = 10'b1010101010; mode_c = 1'b0;
    exp_cnt = 2'd0;
    for (int k = 1; k <= 16; k++) begin
      tick_c(k[0]);
      if (k >= 10 && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
      vectors++;
      if (match_c !== (k >= 10)) begin errors++; $display("FAIL sat_match[tick %0d]: got %b want %b", k, match_c, (k >= 10)); end
      vectors++;
      if (cnt_c !== exp_cnt) begin errors++; $display("FAIL sat_cnt[tick %0d]: got %0d want %0d", k, cnt_c, exp_cnt); end
    end
  endtask

  task automatic test_reset_mid_match();
    logic [9:0] s;
    int n = 0;
    s = 10'b1111011010;
    clear_a();
    pat_a = s; mask_a = '1; mode_a = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick_a(s[i]);
      vectors++;
      if (match_a !== 1'b0) begin errors++; $display("FAIL rst_pre_match[%0d]: got %b want 0", i, match_a); end
    end
    din_a = s[9];
    @(negedge clk);
    while (!samp_a && n < 100) begin @(negedge clk); n++; end
    #1; rst_n = 1'b0; en_a = 1'b0;
    #1;
    vectors++;
    if ({match_a, cnt_a, sh_a, samp_a} !== '0) begin
      errors++;
      $display("FAIL rst_immediate: got match=%b cnt=%0d shreg=%b sample=%b want all 0", match_a, cnt_a, sh_a, samp_a);
    end
    @(posedge clk); #1;
    vectors++; if (match_a !== 1'b0) begin errors++; $display("FAIL rst_pending_pulse: got %b want 0", match_a); end
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(negedge clk);
    en_a = 1'b1; #1;
    n = 1;
    while (!samp_a && n < 50) begin @(negedge clk); #1; n++; end
    vectors++; if (n !== 6) begin errors++; $display("FAIL rst_first_tick: got %0d clk want 6", n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clear_on_tick();
    test_mask();
    test_overlap();
    test_saturate();
    test_reset_mid_match();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
